// File: rtl/spi_ram_responder.sv
// Mode-0 SPI serial-RAM target (READ 0x03 / WRITE 0x02, 24-bit address) backed by a byte array.
// SPI pins are oversampled in the clk domain; host port preloads/inspects the array while idle.
module spi_ram_responder #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 spi_clk_in,
  input  logic                 spi_select,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  output logic                 spi_miso_oe,
  output logic                 busy,
  output logic                 cmd_err,
  input  logic                 host_we,
  input  logic [ADDR_BITS-1:0] host_addr,
  input  logic [7:0]           host_wdata,
  output logic [7:0]           host_rdata
);

  localparam logic [ADDR_BITS-1:0] ADDR_ONE = 1;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, READ, WRITE, IGNORE} state_t;

  state_t                 state;
  logic [7:0]             mem [1 << ADDR_BITS];
  logic [1:0]             sck_sync, mosi_sync, sel_sync, sync_ok;
  logic                   sck_prev, armed, is_read;
  logic [4:0]             bit_cnt;
  logic [22:0]            shift;
  logic [7:0]             tx;
  logic [ADDR_BITS-1:0]   addr;

  logic                   sck_s, mosi_s, sel_s, rise, fall, spi_we, host_wr;
  logic [23:0]            shift_in;
  logic [ADDR_BITS-1:0]   addr_in;

  assign sck_s    = sck_sync[1];
  assign mosi_s   = mosi_sync[1];
  assign sel_s    = sel_sync[1];
  assign rise     = sck_s & ~sck_prev;
  assign fall     = ~sck_s & sck_prev;
  assign shift_in = {shift, mosi_s};
  assign addr_in  = shift_in[ADDR_BITS-1:0];
  assign busy     = ~sel_s;
  assign spi_we   = (state == WRITE) && !sel_s && rise && (bit_cnt == 5'd7);
  assign host_wr  = host_we && (state == IDLE);

  // armed only after the synchronizer has seen a real high select, so a select
  // still held low across reset release cannot start a transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync  <= 2'b00;
      mosi_sync <= 2'b00;
      sel_sync  <= 2'b11;
      sck_prev  <= 1'b0;
      sync_ok   <= 2'b00;
      armed     <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[0], spi_clk_in};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      sel_sync  <= {sel_sync[0], spi_select};
      sck_prev  <= sck_s;
      sync_ok   <= {sync_ok[0], 1'b1};
      if (sync_ok[1] && sel_s) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift       <= '0;
      is_read     <= 1'b0;
      tx          <= '0;
      addr        <= '0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      cmd_err <= 1'b0;
      if (state != IDLE && sel_s) begin
        state       <= IDLE;
        bit_cnt     <= '0;
        spi_miso    <= 1'b0;
        spi_miso_oe <= 1'b0;
      end else begin
        case (state)
          IDLE: if (armed && !sel_s) begin
            state   <= CMD;
            bit_cnt <= '0;
          end
          CMD: if (rise) begin
            shift <= shift_in[22:0];
            if (bit_cnt == 5'd7) begin
              bit_cnt <= '0;
              is_read <= (shift_in[7:0] == 8'h03);
              if (shift_in[7:0] == 8'h03 || shift_in[7:0] == 8'h02) begin
                state <= ADDR;
              end else begin
                state   <= IGNORE;
                cmd_err <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          ADDR: if (rise) begin
            shift <= shift_in[22:0];
            if (bit_cnt == 5'd23) begin
              bit_cnt <= '0;
              if (is_read) begin
                tx          <= mem[addr_in];
                addr        <= addr_in + ADDR_ONE;
                spi_miso_oe <= 1'b1;
                state       <= READ;
              end else begin
                addr  <= addr_in;
                state <= WRITE;
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          // the 8th fall drives bit 0 and preloads the next byte for the following fall
          READ: if (fall) begin
            spi_miso <= tx[7];
            if (bit_cnt == 5'd7) begin
              bit_cnt <= '0;
              tx      <= mem[addr];
              addr    <= addr + ADDR_ONE;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
              tx      <= {tx[6:0], 1'b0};
            end
          end
          WRITE: if (rise) begin
            shift <= shift_in[22:0];
            if (bit_cnt == 5'd7) begin
              bit_cnt <= '0;
              addr    <= addr + ADDR_ONE;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (spi_we) mem[addr] <= shift_in[7:0];
    else if (host_wr) mem[host_addr] <= host_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) host_rdata <= '0;
    else     host_rdata <= mem[host_addr];
  end

endmodule
